etapa_ex: RTL and testbench
===========================

ETAPA_EX -- requirements
Module: etapa_ex

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width; only 32 is verified.
REQ-002 Parameter MUL_ITER, default 32, multiply iterations; SHALL equal DATA_W.
REQ-003 clk_ex  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_ex  input  1  reset, asynchronous, active-high.
REQ-005 valid_in  input  1  operands/function from ID/EX buffer are valid this cycle.
REQ-006 op_a  input  DATA_W  operand A (ID/EX first data output).
REQ-007 op_b  input  DATA_W  operand B (ID/EX second data output).
REQ-008 alu_func  input  4  ALU function code (ID/EX function output).
REQ-009 stall_in  input  1  downstream (MEM) cannot accept; hold outputs.
REQ-010 busy  output  1  upstream SHALL hold op_a/op_b/alu_func/valid_in while high.
REQ-011 result_out  output  DATA_W  registered EX/MEM result.
REQ-012 zero_out  output  1  registered, result_out == 0.
REQ-013 ovf_out  output  1  registered signed overflow (ADD/SUB only).
REQ-014 ill_op  output  1  registered, unsupported alu_func accepted.
REQ-015 valid_out  output  1  result_out/flags valid this cycle.

Function
REQ-016 Encoding: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB, 0111 SLT (signed), 1000 SLL, 1001 SRL, 1010 SRA, 1011 MUL, 1100 NOR; shift amount op_b[4:0].
REQ-017 Any other code: result 0, ill_op 1, valid_out 1, single-cycle latency.
REQ-018 States: IDLE, MUL, DONE; reset state IDLE.
REQ-019 Accept occurs when valid_in=1 and busy=0.
REQ-020 busy = stall_in OR state is MUL OR state is DONE (combinational).
REQ-021 Single-cycle op accepted at edge N: outputs updated at edge N+1 with valid_out=1.
REQ-022 ADD/SUB wrap modulo 2^DATA_W; ovf_out=1 when operand signs (B inverted for SUB) agree and result sign differs; ovf_out=0 for all other ops.
REQ-023 SLT: result 1 when signed op_a < signed op_b, else 0.
REQ-024 MUL accept: IDLE->MUL, load multiplicand op_a, multiplier op_b, accumulator 0, counter MUL_ITER; valid_out=0 next edge.
REQ-025 MUL: each cycle add multiplicand to accumulator if multiplier[0]=1, shift multiplicand left 1, multiplier right 1, decrement counter.
REQ-026 Counter reaching 0: if stall_in=0 register low DATA_W bits of product, valid_out=1, go IDLE; if stall_in=1 go DONE holding product.
REQ-027 DONE: when stall_in=0, register product, valid_out=1, go IDLE.
REQ-028 Unaccepted MUL latency: MUL_ITER+1 edges from accept to valid_out=1; ovf_out=0, ill_op=0.
REQ-029 stall_in=1: result_out, zero_out, ovf_out, ill_op, valid_out all hold previous values; MUL iterations continue.
REQ-030 No accept and stall_in=0 in IDLE: valid_out=0 next edge, result_out holds.
REQ-031 valid_in=1 while busy=1 SHALL be ignored (no accept, no state change from it).
REQ-032 stall_in rising on same edge a single-cycle op presents: no accept (busy=1); op accepted on first cycle stall_in=0.

Reset
REQ-033 reset_ex=1 immediately forces state IDLE, counter 0, accumulator 0, result_out 0, zero_out 0, ovf_out 0, ill_op 0, valid_out 0, independent of clk_ex.
REQ-034 Reset mid-MUL or in DONE SHALL discard the operation; no valid_out after release until a new accept.
REQ-035 First accept possible on first rising edge after reset_ex falls.

Verification
REQ-036 ADD 0x7FFFFFFF + 0x00000001, valid_in=1 one cycle -> next edge result_out=0x80000000, ovf_out=1, zero_out=0, valid_out=1.
REQ-037 SUB 5 - 5 -> result_out=0, zero_out=1, ovf_out=0; SLT 0xFFFFFFFF vs 1 -> result_out=1.
REQ-038 MUL 0x00010003 x 0x00000005, stall_in=0 -> busy high 33 cycles, valid_out=1 exactly 33 edges after accept, result_out=0x0005000F.
REQ-039 MUL with stall_in=1 from iteration 30 to 5 cycles after finish -> state DONE, busy=1, valid_out=0 until stall_in falls, then result_out correct next edge.
REQ-040 alu_func=0101 -> result_out=0, ill_op=1, valid_out=1; next ADD clears ill_op.
REQ-041 reset_ex asserted mid-MUL iteration 10 between edges -> all outputs 0 immediately; after release valid_out stays 0 with valid_in=0.

Source files
------------

// File: rtl/etapa_ex_if.sv
// etapa_ex_if -- ID/EX -> EX -> EX/MEM stage bus.
// Groups the operand/function handshake coming from the ID/EX buffer, the
// downstream stall, and the registered EX/MEM results with their flags.
//   valid_in, op_a, op_b, alu_func : operands/function from ID/EX
//   stall_in                       : MEM cannot accept, EX holds its outputs
//   busy                           : upstream must hold its request while high
//   result_out, zero_out, ovf_out,
//   ill_op, valid_out              : registered EX/MEM result and flags
// master = upstream/downstream environment, slave = the EX stage.
interface etapa_ex_if #(
  parameter int DATA_W = 32
) ();
  logic              valid_in;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [3:0]        alu_func;
  logic              stall_in;
  logic              busy;
  logic [DATA_W-1:0] result_out;
  logic              zero_out;
  logic              ovf_out;
  logic              ill_op;
  logic              valid_out;

  modport master (
    output valid_in, op_a, op_b, alu_func, stall_in,
    input  busy, result_out, zero_out, ovf_out, ill_op, valid_out
  );

  modport slave (
    input  valid_in, op_a, op_b, alu_func, stall_in,
    output busy, result_out, zero_out, ovf_out, ill_op, valid_out
  );
endinterface

// File: rtl/etapa_ex.sv
// etapa_ex -- pipeline execute stage.
// Single-cycle ALU (AND/OR/ADD/XOR/SUB/SLT/SLL/SRL/SRA/NOR) registered into
// the EX/MEM outputs, plus an iterative shift-add multiplier (MUL) that keeps
// the stage busy for MUL_ITER+1 cycles.
// Ports:
//   clk_ex   : clock, rising edge
//   reset_ex : asynchronous active-high reset
//   bus      : etapa_ex_if slave (operands in, stall in, busy/results out)
module etapa_ex #(
  parameter int DATA_W   = 32,
  parameter int MUL_ITER = 32
) (
  input  logic       clk_ex,
  input  logic       reset_ex,
  etapa_ex_if.slave  bus
);

  localparam int CNT_W = $clog2(MUL_ITER + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_ITER);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] F_AND = 4'b0000;
  localparam logic [3:0] F_OR  = 4'b0001;
  localparam logic [3:0] F_ADD = 4'b0010;
  localparam logic [3:0] F_XOR = 4'b0011;
  localparam logic [3:0] F_SUB = 4'b0110;
  localparam logic [3:0] F_SLT = 4'b0111;
  localparam logic [3:0] F_SLL = 4'b1000;
  localparam logic [3:0] F_SRL = 4'b1001;
  localparam logic [3:0] F_SRA = 4'b1010;
  localparam logic [3:0] F_MUL = 4'b1011;
  localparam logic [3:0] F_NOR = 4'b1100;

  // Signed overflow: both addend signs agree and the sum sign differs.
  // For SUB the caller passes the inverted sign of op_b.
  function automatic logic ovf_chk(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplr_q, mplr_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic              ovf_q, ovf_d;
  logic              ill_q, ill_d;
  logic              valid_q, valid_d;

  logic              busy;
  logic              accept;
  logic [DATA_W-1:0] alu_res;
  logic              alu_ovf;
  logic              alu_ill;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic signed [DATA_W-1:0] sa;
  logic signed [DATA_W-1:0] sb;
  logic signed [DATA_W-1:0] sra_res;
  logic [4:0]        shamt;

  assign busy   = bus.stall_in | (state_q != ST_IDLE);
  assign accept = bus.valid_in & ~busy;

  // Single-cycle ALU (combinational, registered below)
  always_comb begin
    sa      = signed'(bus.op_a);
    sb      = signed'(bus.op_b);
    shamt   = bus.op_b[4:0];
    sum     = bus.op_a + bus.op_b;
    diff    = bus.op_a - bus.op_b;
    sra_res = sa >>> shamt;
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (bus.alu_func)
      F_AND: alu_res = bus.op_a & bus.op_b;
      F_OR:  alu_res = bus.op_a | bus.op_b;
      F_ADD: begin
        alu_res = sum;
        alu_ovf = ovf_chk(bus.op_a[DATA_W-1], bus.op_b[DATA_W-1], sum[DATA_W-1]);
      end
      F_XOR: alu_res = bus.op_a ^ bus.op_b;
      F_SUB: begin
        alu_res = diff;
        alu_ovf = ovf_chk(bus.op_a[DATA_W-1], ~bus.op_b[DATA_W-1], diff[DATA_W-1]);
      end
      F_SLT: alu_res = {{(DATA_W-1){1'b0}}, (sa < sb)};
      F_SLL: alu_res = bus.op_a << shamt;
      F_SRL: alu_res = bus.op_a >> shamt;
      F_SRA: alu_res = unsigned'(sra_res);
      F_MUL: alu_res = '0;  // handled by the iterative multiplier
      F_NOR: alu_res = ~(bus.op_a | bus.op_b);
      default: alu_ill = 1'b1;
    endcase
  end

  // Control / next-state
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;
    valid_d  = valid_q;

    // Outputs are frozen while MEM stalls; otherwise an idle cycle drops valid.
    if (!bus.stall_in) valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bus.alu_func == F_MUL) begin
            state_d = ST_MUL;
            mcand_d = bus.op_a;
            mplr_d  = bus.op_b;
            acc_d   = '0;
            cnt_d   = CNT_LOAD;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            ovf_d    = alu_ovf;
            ill_d    = alu_ill;
            valid_d  = 1'b1;
          end
        end
      end
      ST_MUL: begin
        // Iterations run regardless of stall; only the final write-back waits.
        if (cnt_q != '0) begin
          acc_d   = acc_q + (mplr_q[0] ? mcand_q : '0);
          mcand_d = mcand_q << 1;
          mplr_d  = mplr_q >> 1;
          cnt_d   = cnt_q - CNT_W'(1);
        end else if (!bus.stall_in) begin
          result_d = acc_q;
          zero_d   = (acc_q == '0);
          ovf_d    = 1'b0;
          ill_d    = 1'b0;
          valid_d  = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!bus.stall_in) begin
          result_d = acc_q;
          zero_d   = (acc_q == '0);
          ovf_d    = 1'b0;
          ill_d    = 1'b0;
          valid_d  = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_ex or posedge reset_ex) begin
    if (reset_ex) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
      valid_q  <= valid_d;
    end
  end

  // Multiplier operand shift registers (always reloaded on accept)
  always_ff @(posedge clk_ex) begin
    mcand_q <= mcand_d;
    mplr_q  <= mplr_d;
  end

  assign bus.busy       = busy;
  assign bus.result_out = result_q;
  assign bus.zero_out   = zero_q;
  assign bus.ovf_out    = ovf_q;
  assign bus.ill_op     = ill_q;
  assign bus.valid_out  = valid_q;

endmodule

// File: tb/tb_etapa_ex.sv
module tb_etapa_ex;

  localparam logic [3:0] F_AND = 4'b0000;
  localparam logic [3:0] F_OR  = 4'b0001;
  localparam logic [3:0] F_ADD = 4'b0010;
  localparam logic [3:0] F_XOR = 4'b0011;
  localparam logic [3:0] F_ILL = 4'b0101;
  localparam logic [3:0] F_SUB = 4'b0110;
  localparam logic [3:0] F_SLT = 4'b0111;
  localparam logic [3:0] F_SLL = 4'b1000;
  localparam logic [3:0] F_SRL = 4'b1001;
  localparam logic [3:0] F_SRA = 4'b1010;
  localparam logic [3:0] F_MUL = 4'b1011;
  localparam logic [3:0] F_NOR = 4'b1100;

  typedef struct {
    logic [31:0] r;
    logic        z;
    logic        o;
    logic        i;
  } exp_t;

  logic clk_ex   = 1'b0;
  logic reset_ex = 1'b1;
  int   n_chk    = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  logic mon_stall;

  always #5 clk_ex = ~clk_ex;

  etapa_ex_if #(.DATA_W(32)) bus ();

  etapa_ex #(.DATA_W(32), .MUL_ITER(32)) dut (
    .clk_ex   (clk_ex),
    .reset_ex (reset_ex),
    .bus      (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: a new result is presented on every edge where valid_out is high
  // and the stage was not stalled (a stalled stage just holds the old one).
  always @(posedge clk_ex) begin
    exp_t e;
    mon_stall = bus.stall_in;
    #1;
    if (!reset_ex && !mon_stall && bus.valid_out) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected: got valid result 0x%08h expected no output at %0t",
                 bus.result_out, $time);
      end else begin
        e = sb.pop_front();
        chk("sb_result", bus.result_out, e.r);
        chk("sb_zero", {31'd0, bus.zero_out}, {31'd0, e.z});
        chk("sb_ovf", {31'd0, bus.ovf_out}, {31'd0, e.o});
        chk("sb_ill", {31'd0, bus.ill_op}, {31'd0, e.i});
      end
    end
  end

  // Present one request for a cycle once the stage is free; returns on the
  // falling edge right after the accepting edge.
  task automatic issue(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic o, input logic i, input bit push);
    int t;
    exp_t e;
    t = 0;
    while (bus.busy && t < 200) begin
      @(negedge clk_ex);
      t++;
    end
    chk("issue_busy_timeout", {31'd0, bus.busy}, 32'd0);
    bus.valid_in = 1'b1;
    bus.alu_func = f;
    bus.op_a     = a;
    bus.op_b     = b;
    if (push) begin
      e.r = r;
      e.z = (r == 32'd0);
      e.o = o;
      e.i = i;
      sb.push_back(e);
    end
    @(negedge clk_ex);
    bus.valid_in = 1'b0;
  endtask

  initial begin
    int  bc;
    bit  vb;
    bit  bb;
    bus.valid_in = 1'b0;
    bus.op_a     = '0;
    bus.op_b     = '0;
    bus.alu_func = '0;
    bus.stall_in = 1'b0;

    // Reset state
    repeat (3) @(negedge clk_ex);
    chk("rst_result", bus.result_out, 32'd0);
    chk("rst_valid", {31'd0, bus.valid_out}, 32'd0);
    chk("rst_flags", {29'd0, bus.zero_out, bus.ovf_out, bus.ill_op}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    reset_ex = 1'b0;

    // Single-cycle ALU vectors
    issue(F_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
    chk("add_valid_next_edge", {31'd0, bus.valid_out}, 32'd1);
    issue(F_SUB, 32'd5, 32'd5, 32'd0, 1'b0, 1'b0, 1'b1);
    issue(F_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1'b1);
    issue(F_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1'b1);
    issue(F_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0, 1'b1);
    issue(F_OR,  32'h1200_0034, 32'h0056_7800, 32'h1256_7834, 1'b0, 1'b0, 1'b1);
    issue(F_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0, 1'b1);
    issue(F_NOR, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    issue(F_SLL, 32'd1, 32'h0000_003F, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    issue(F_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1'b0, 1'b1);
    issue(F_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0, 1'b1);
    issue(F_SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1);
    issue(F_ADD, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1'b1);
    issue(F_ILL, 32'd9, 32'd9, 32'd0, 1'b0, 1'b1, 1'b1);
    issue(F_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b1);

    // MUL, no stall: busy for 33 cycles, result right after
    issue(F_MUL, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 1'b0, 1'b0, 1'b1);
    bc = 0;
    vb = 1'b0;
    while (bus.busy && bc < 100) begin
      if (bus.valid_out) vb = 1'b1;
      bc++;
      @(negedge clk_ex);
    end
    chk("mul_busy_cycles", bc, 32'd33);
    chk("mul_valid_while_busy", {31'd0, vb}, 32'd0);
    chk("mul_valid_after", {31'd0, bus.valid_out}, 32'd1);

    // MUL with stall from iteration 30 until well after the count ends;
    // a request presented during the stall must be ignored.
    issue(F_MUL, 32'h1234_5678, 32'h0000_0009, 32'hA3D7_0A38, 1'b0, 1'b0, 1'b1);
    repeat (29) @(negedge clk_ex);
    bus.stall_in = 1'b1;
    bb = 1'b1;
    vb = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk_ex);
      if (!bus.busy) bb = 1'b0;
      if (bus.valid_out) vb = 1'b1;
      if (k == 2) begin
        bus.valid_in = 1'b1;
        bus.alu_func = F_ADD;
        bus.op_a     = 32'd10;
        bus.op_b     = 32'd20;
      end
      if (k == 6) bus.valid_in = 1'b0;
    end
    chk("stall_mul_busy", {31'd0, bb}, 32'd1);
    chk("stall_mul_no_valid", {31'd0, vb}, 32'd0);
    bus.stall_in = 1'b0;
    chk("done_busy_after_release", {31'd0, bus.busy}, 32'd1);
    @(negedge clk_ex);
    chk("done_valid", {31'd0, bus.valid_out}, 32'd1);
    chk("done_not_busy", {31'd0, bus.busy}, 32'd0);

    // Outputs hold under stall, then valid drops on an idle cycle
    bus.stall_in = 1'b1;
    repeat (2) @(negedge clk_ex);
    chk("hold_valid", {31'd0, bus.valid_out}, 32'd1);
    chk("hold_result", bus.result_out, 32'hA3D7_0A38);
    bus.stall_in = 1'b0;
    @(negedge clk_ex);
    chk("idle_valid_low", {31'd0, bus.valid_out}, 32'd0);
    chk("idle_result_hold", bus.result_out, 32'hA3D7_0A38);

    // Request arriving together with a stall waits for the stall to clear
    begin
      exp_t e;
      e.r = 32'h0000_0123; e.z = 1'b0; e.o = 1'b0; e.i = 1'b0;
      sb.push_back(e);
    end
    bus.stall_in = 1'b1;
    bus.valid_in = 1'b1;
    bus.alu_func = F_ADD;
    bus.op_a     = 32'h0000_0100;
    bus.op_b     = 32'h0000_0023;
    vb = 1'b0;
    repeat (3) begin
      @(negedge clk_ex);
      if (bus.valid_out) vb = 1'b1;
    end
    chk("stall_op_not_accepted", {31'd0, vb}, 32'd0);
    bus.stall_in = 1'b0;
    @(negedge clk_ex);
    bus.valid_in = 1'b0;
    chk("stall_op_accepted", {31'd0, bus.valid_out}, 32'd1);

    // Reset in the middle of a MUL discards it
    issue(F_ADD, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1);
    issue(F_MUL, 32'd7, 32'd6, 32'd42, 1'b0, 1'b0, 1'b0);
    repeat (10) @(posedge clk_ex);
    #2 reset_ex = 1'b1;
    #1;
    chk("midrst_result", bus.result_out, 32'd0);
    chk("midrst_flags", {29'd0, bus.zero_out, bus.ovf_out, bus.ill_op}, 32'd0);
    chk("midrst_valid", {31'd0, bus.valid_out}, 32'd0);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk_ex);
    reset_ex = 1'b0;
    vb = 1'b0;
    repeat (40) begin
      @(negedge clk_ex);
      if (bus.valid_out) vb = 1'b1;
    end
    chk("midrst_no_valid_after", {31'd0, vb}, 32'd0);

    // First accept on the first edge after reset falls
    reset_ex = 1'b1;
    @(negedge clk_ex);
    reset_ex = 1'b0;
    issue(F_ADD, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1'b1);
    chk("post_rst_first_accept", {31'd0, bus.valid_out}, 32'd1);

    repeat (3) @(negedge clk_ex);
    chk("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
